cic_interpolator: RTL and testbench

- Hogenauer CIC interpolator: the transmit-side counterpart to the CIC decimator and its compensating FIR.
- Accepts one low-rate 2's-complement sample and produces Rate high-rate output samples through N comb stages, a zero-stuffing upsampler and N integrator stages.
- Sits between a baseband source or pre-compensating filter and a DAC/upconverter.
- Valid/ready handshake on both sides; downstream backpressure stalls the integrators.

---
 rtl/cic_interpolator.sv | 130 +++++++++++++
 tb/tb_cic_interpolator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// Hogenauer CIC interpolator: N low-rate combs, zero-stuffing by Rate, N high-rate integrators.
// Valid/ready on both sides; downstream backpressure holds the integrators.
module cic_interpolator #(
    parameter int InputLengthBits   = 16,
    parameter int Rate              = 8,
    parameter int FilterOrder       = 3,
    parameter int DifferentialDelay = 1,
    parameter int OutputLengthBits  = 22
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [InputLengthBits-1:0]  in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [OutputLengthBits-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int PhaseBits = (Rate > 2) ? $clog2(Rate) : 1;

    function automatic longint dc_gain();
        longint g = 1;
        for (int unsigned k = 0; k < FilterOrder; k++) begin
            g = g * longint'(Rate * DifferentialDelay);
        end
        return g / Rate;
    endfunction

    localparam longint DcGain      = dc_gain();
    localparam int     MinOutWidth = InputLengthBits + $clog2(DcGain);

    if (Rate < 2 || FilterOrder < 1 || FilterOrder > 7 ||
        DifferentialDelay < 1 || DifferentialDelay > 2 ||
        OutputLengthBits < MinOutWidth) begin : g_param_check
        $error("cic_interpolator: illegal parameters or OutputLengthBits below required growth");
    end

    typedef logic signed [OutputLengthBits-1:0] word_t;
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state, state_next;
    word_t                 comb_dly [FilterOrder][DifferentialDelay];
    word_t                 comb_val [FilterOrder+1];
    word_t                 comb_out;
    word_t                 integ      [FilterOrder];
    word_t                 integ_next [FilterOrder];
    word_t                 stuffed;
    logic [PhaseBits-1:0]  phase;
    logic                  accept;
    logic                  step;

    // Comb chain evaluated on the presented sample; committed only on acceptance.
    always_comb begin
        comb_val[0] = word_t'($signed(in));
        for (int unsigned k = 0; k < FilterOrder; k++) begin
            comb_val[k+1] = comb_val[k] - comb_dly[k][DifferentialDelay-1];
        end
    end

    always_comb begin
        stuffed       = (phase == '0) ? comb_out : '0;
        integ_next[0] = integ[0] + stuffed;
        for (int unsigned k = 1; k < FilterOrder; k++) begin
            integ_next[k] = integ[k] + integ_next[k-1];
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                step = !out_valid || out_ready;
                if (step && phase == PhaseBits'(Rate - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            comb_out  <= '0;
            phase     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            for (int unsigned k = 0; k < FilterOrder; k++) begin
                integ[k] <= '0;
                for (int unsigned m = 0; m < DifferentialDelay; m++) begin
                    comb_dly[k][m] <= '0;
                end
            end
        end else begin
            state <= state_next;
            if (accept) begin
                comb_out <= comb_val[FilterOrder];
                phase    <= '0;
                for (int unsigned k = 0; k < FilterOrder; k++) begin
                    comb_dly[k][0] <= comb_val[k];
                    for (int unsigned m = 1; m < DifferentialDelay; m++) begin
                        comb_dly[k][m] <= comb_dly[k][m-1];
                    end
                end
            end
            if (step) begin
                for (int unsigned k = 0; k < FilterOrder; k++) begin
                    integ[k] <= integ_next[k];
                end
                out       <= integ_next[FilterOrder-1];
                out_valid <= 1'b1;
                phase     <= phase + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (R=8, N=3, M=1, 16-bit in, 22-bit out).
module tb_cic_interpolator;

    logic               clk;
    logic               rst;
    logic signed [15:0] din;
    logic               in_valid;
    logic               in_ready;
    logic        [21:0] dout;
    logic               out_valid;
    logic               out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;

    logic signed [21:0] got [$];
    logic               s_acc, s_hs, s_ov, s_ir, s_ordy;
    logic signed [21:0] s_out;

    // Impulse response of (1 + z^-1 + ... + z^-7)^3, followed by zeros.
    int imp_exp [32] = '{1, 3, 6, 10, 15, 21, 28, 36,
                         42, 46, 48, 48, 46, 42, 36, 28,
                         21, 15, 10, 6, 3, 1, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0};

    cic_interpolator #(
        .InputLengthBits(16),
        .Rate(8),
        .FilterOrder(3),
        .DifferentialDelay(1),
        .OutputLengthBits(22)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(din),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(dout),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: sample on the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_acc  = in_valid && in_ready;
        s_hs   = out_valid && out_ready;
        s_ov   = out_valid;
        s_ir   = in_ready;
        s_ordy = out_ready;
        s_out  = $signed(dout);
        if (s_hs && !rst) got.push_back($signed(dout));
        @(posedge clk);
        #1;
        if (s_acc && !rst) n_acc++;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        cycle();
        cycle();
        rst   = 1'b0;
        n_acc = 0;
        got.delete();
    endtask

    // Feed `first` as sample 0 and `rest` afterwards until n_out outputs are consumed.
    task automatic run_stream(input logic signed [15:0] first, input logic signed [15:0] rest,
                              input int n_out);
        do_reset();
        in_valid = 1'b1;
        din      = first;
        for (int i = 0; i < 20 * n_out && got.size() < n_out; i++) begin
            cycle();
            din = (n_acc == 0) ? first : rest;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        total++;
        if (s_ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", s_ov); end
        total++;
        if (s_ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", s_ir); end
        total++;
        if (s_out !== 22'sd0) begin bad++; $display("FAIL reset_out got=%0d want=0", s_out); end
    endtask

    task automatic test_impulse();
        run_stream(16'sd1, 16'sd0, 32);
        total++;
        if (got.size() != 32) begin bad++; $display("FAIL impulse_count got=%0d want=32", got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 22'(imp_exp[i])) begin
                bad++;
                $display("FAIL impulse[%0d] got=%0d want=%0d", i, got[i], imp_exp[i]);
            end
        end
    endtask

    task automatic test_dc_step();
        run_stream(16'sd100, 16'sd100, 40);
        total++;
        if (got.size() != 40) begin bad++; $display("FAIL dc_count got=%0d want=40", got.size()); end
        if (got.size() == 40) begin
            total++;
            if (got[0] !== 22'sd100) begin bad++; $display("FAIL dc_first got=%0d want=100", got[0]); end
            total++;
            if (got[7] !== 22'sd3600) begin bad++; $display("FAIL dc_phase7 got=%0d want=3600", got[7]); end
            for (int i = 16; i < 40; i++) begin
                total++;
                if (got[i] !== 22'sd6400) begin
                    bad++;
                    $display("FAIL dc_steady[%0d] got=%0d want=6400", i, got[i]);
                end
            end
        end
    endtask

    task automatic test_full_scale();
        run_stream(-16'sd32768, -16'sd32768, 32);
        total++;
        if (got.size() != 32) begin bad++; $display("FAIL fs_neg_count got=%0d want=32", got.size()); end
        for (int i = 16; i < 32 && i < got.size(); i++) begin
            total++;
            if (got[i] !== -22'sd2097152) begin
                bad++;
                $display("FAIL fs_neg[%0d] got=%0d want=-2097152", i, got[i]);
            end
        end
        run_stream(16'sd32767, 16'sd32767, 32);
        total++;
        if (got.size() != 32) begin bad++; $display("FAIL fs_pos_count got=%0d want=32", got.size()); end
        for (int i = 16; i < 32 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 22'sd2097088) begin
                bad++;
                $display("FAIL fs_pos[%0d] got=%0d want=2097088", i, got[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic               prev_stall;
        logic signed [21:0] prev_out;
        int                 got_before, acc_before;
        do_reset();
        prev_stall = 1'b0;
        prev_out   = '0;
        in_valid   = 1'b1;
        din        = 16'sd1;
        out_ready  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 600 && got.size() < 32; i++) begin
            cycle();
            if (prev_stall) begin
                total++;
                if (!s_ov || s_out !== prev_out) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%0d/%0b want=%0d/1", cyc, s_out, s_ov, prev_out);
                end
            end
            if (s_ir) begin
                got_before = got.size() - (s_hs ? 1 : 0);
                acc_before = n_acc - (s_acc ? 1 : 0);
                total++;
                if (got_before < 8 * acc_before - 1) begin
                    bad++;
                    $display("FAIL bp_in_ready cyc=%0d consumed=%0d want>=%0d", cyc, got_before,
                             8 * acc_before - 1);
                end
            end
            prev_stall = s_ov && !s_ordy;
            prev_out   = s_out;
            din        = (n_acc == 0) ? 16'sd1 : 16'sd0;
            out_ready  = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got.size() != 32) begin bad++; $display("FAIL bp_count got=%0d want=32", got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 22'(imp_exp[i])) begin
                bad++;
                $display("FAIL bp_seq[%0d] got=%0d want=%0d", i, got[i], imp_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in_valid = 1'b1;
        din      = 16'sd1;
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            cycle();
            din = (n_acc == 0) ? 16'sd1 : 16'sd0;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        total++;
        if (s_ov !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%0b want=0", s_ov); end
        total++;
        if (s_ir !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%0b want=1", s_ir); end
        total++;
        if (s_out !== 22'sd0) begin bad++; $display("FAIL mid_rst_out got=%0d want=0", s_out); end
        got.delete();
        n_acc    = 0;
        in_valid = 1'b1;
        din      = 16'sd1;
        for (int i = 0; i < 40 && got.size() < 3; i++) begin
            cycle();
            din = (n_acc == 0) ? 16'sd1 : 16'sd0;
        end
        in_valid = 1'b0;
        total++;
        if (got.size() != 3) begin bad++; $display("FAIL mid_rst_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== 22'(imp_exp[i])) begin
                bad++;
                $display("FAIL mid_rst_restart[%0d] got=%0d want=%0d", i, got[i], imp_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        int first_ov;
        do_reset();
        first_ov = -1;
        in_valid = 1'b1;
        din      = 16'sd5;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_acc) acc_cyc.push_back(cyc - 1);
            if (s_ov && first_ov < 0) first_ov = cyc - 1;
        end
        in_valid = 1'b0;
        total++;
        if (acc_cyc.size() < 4) begin bad++; $display("FAIL b2b_accepts got=%0d want>=4", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != 9) begin
                bad++;
                $display("FAIL b2b_interval[%0d] got=%0d want=9", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        if (acc_cyc.size() > 0) begin
            total++;
            if (first_ov != acc_cyc[0] + 2) begin
                bad++;
                $display("FAIL b2b_latency got=%0d want=%0d", first_ov - acc_cyc[0], 2);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_dc_step();
        test_full_scale();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
